// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master Wishbone arbiter in front of the single memory
// slave path. Master 0 is the CPU and master 1 is a secondary requester
// such as video refresh or DMA. One master owns the slave per transfer,
// and the grant is registered, so arbitration costs one cycle. Address,
// data and ack are then routed combinationally between the owner and the
// slave. A watchdog forces completion of a transfer whose slave never
// acks, so a hung slave cannot stall the CPU.
module mem_arbiter #(
    parameter int unsigned TIMEOUT     = 64,  // legal 2..255
    parameter int unsigned M0_PRIORITY = 1    // 1: m0 wins ties, 0: round-robin
) (
    input  logic        clk_i,
    input  logic        rst_i,      // asynchronous, active-low

    input  logic [19:0] m0_adr_i,
    input  logic [15:0] m0_dat_i,
    output logic [15:0] m0_dat_o,
    input  logic        m0_we_i,
    input  logic        m0_byte_i,
    input  logic        m0_stb_i,
    output logic        m0_ack_o,

    input  logic [19:0] m1_adr_i,
    input  logic [15:0] m1_dat_i,
    output logic [15:0] m1_dat_o,
    input  logic        m1_we_i,
    input  logic        m1_byte_i,
    input  logic        m1_stb_i,
    output logic        m1_ack_o,

    output logic [19:0] s_adr_o,
    output logic [15:0] s_dat_o,
    input  logic [15:0] s_dat_i,
    output logic        s_we_o,
    output logic        s_byte_o,
    output logic        s_stb_o,
    input  logic        s_ack_i,

    output logic        tmo_o,
    output logic [1:0]  gnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GNT0 = 2'b01,
        ST_GNT1 = 2'b10
    } state_t;

    // Counter value at which an unacknowledged transfer is forced to end.
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 32'd1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic        last_gnt_r;      // 0: m0 was served last, 1: m1 was
    logic        last_gnt_nxt_s;
    logic [7:0]  wd_cnt_r;
    logic [7:0]  wd_cnt_nxt_s;

    logic        granted_s;       // some master owns the slave this cycle
    logic        sel_m1_s;        // slave-side mux selects master 1
    logic        req_s;           // strobe of the owning master
    logic        expire_s;        // watchdog fires this cycle
    logic        ack_s;           // ack returned to the owning master
    logic [15:0] rd_s;            // read data returned to the owning master
    logic        we_sel_s;
    logic        slave_stb_s;

    // Decode the owner of the slave from the registered grant state.
    always_comb begin
        granted_s = 1'b0;
        sel_m1_s  = 1'b0;
        req_s     = 1'b0;
        case (state_r)
            ST_GNT0: begin
                granted_s = 1'b1;
                sel_m1_s  = 1'b0;
                req_s     = m0_stb_i;
            end
            ST_GNT1: begin
                granted_s = 1'b1;
                sel_m1_s  = 1'b1;
                req_s     = m1_stb_i;
            end
            default: begin
                granted_s = 1'b0;
                sel_m1_s  = 1'b0;
                req_s     = 1'b0;
            end
        endcase
    end

    // A real slave ack in the expiry cycle wins over the watchdog; an
    // aborted strobe is not a timeout either.
    assign expire_s = granted_s & req_s & ~s_ack_i & (wd_cnt_r == WD_LAST);
    assign ack_s    = granted_s & (s_ack_i | expire_s);
    assign rd_s     = expire_s ? 16'hFFFF : s_dat_i;

    // Route the owning master onto the slave; m0 is the idle default.
    always_comb begin
        s_adr_o     = m0_adr_i;
        s_dat_o     = m0_dat_i;
        s_byte_o    = m0_byte_i;
        we_sel_s    = m0_we_i;
        if (sel_m1_s) begin
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_byte_o = m1_byte_i;
            we_sel_s = m1_we_i;
        end else begin
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_byte_o = m0_byte_i;
            we_sel_s = m0_we_i;
        end
        slave_stb_s = req_s & ~expire_s;
        s_stb_o     = slave_stb_s;
        s_we_o      = we_sel_s & slave_stb_s;
    end

    // Return data and ack to the owner only; the other master sees zeros.
    always_comb begin
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_dat_o = 16'h0000;
        m1_dat_o = 16'h0000;
        case (state_r)
            ST_GNT0: begin
                m0_ack_o = ack_s;
                m0_dat_o = rd_s;
            end
            ST_GNT1: begin
                m1_ack_o = ack_s;
                m1_dat_o = rd_s;
            end
            default: begin
                m0_ack_o = 1'b0;
                m1_ack_o = 1'b0;
                m0_dat_o = 16'h0000;
                m1_dat_o = 16'h0000;
            end
        endcase
    end

    // One-hot view of the current grant plus the watchdog pulse.
    always_comb begin
        tmo_o = expire_s;
        case (state_r)
            ST_GNT0: gnt_o = 2'b01;
            ST_GNT1: gnt_o = 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    // Arbitration, release, abort and watchdog next-state logic.
    always_comb begin
        state_nxt_s    = state_r;
        last_gnt_nxt_s = last_gnt_r;
        wd_cnt_nxt_s   = wd_cnt_r;
        case (state_r)
            ST_IDLE: begin
                wd_cnt_nxt_s = 8'd0;
                if (m0_stb_i && m1_stb_i) begin
                    if ((M0_PRIORITY != 32'd0) || last_gnt_r) begin
                        state_nxt_s = ST_GNT0;
                    end else begin
                        state_nxt_s = ST_GNT1;
                    end
                end else if (m0_stb_i) begin
                    state_nxt_s = ST_GNT0;
                end else if (m1_stb_i) begin
                    state_nxt_s = ST_GNT1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GNT0, ST_GNT1: begin
                if (s_ack_i || expire_s) begin
                    // Completed (really or forced): remember who was served.
                    state_nxt_s    = ST_IDLE;
                    last_gnt_nxt_s = (state_r == ST_GNT1);
                    wd_cnt_nxt_s   = 8'd0;
                end else if (!req_s) begin
                    // Master withdrew its strobe: drop the grant silently.
                    state_nxt_s  = ST_IDLE;
                    wd_cnt_nxt_s = 8'd0;
                end else begin
                    state_nxt_s  = state_r;
                    wd_cnt_nxt_s = wd_cnt_r + 8'd1;
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                wd_cnt_nxt_s = 8'd0;
            end
        endcase
    end

    // State, round-robin memory and watchdog registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r    <= ST_IDLE;
            last_gnt_r <= 1'b1;
            wd_cnt_r   <= 8'd0;
        end else begin
            state_r    <= state_nxt_s;
            last_gnt_r <= last_gnt_nxt_s;
            wd_cnt_r   <= wd_cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances share every input, one with fixed
// m0 priority and TIMEOUT 8, one round-robin with TIMEOUT 5. A transfer-
// level reference model predicts all outputs of both every cycle; directed
// steps follow the test plan, then a randomized phase runs.
module tb_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [19:0] m0_adr_i = 20'h0, m1_adr_i = 20'h0;
    logic [15:0] m0_dat_i = 16'h0, m1_dat_i = 16'h0, s_dat_i = 16'h0;
    logic        m0_we_i = 1'b0, m0_byte_i = 1'b0, m0_stb_i = 1'b0;
    logic        m1_we_i = 1'b0, m1_byte_i = 1'b0, m1_stb_i = 1'b0;
    logic        s_ack_i = 1'b0;

    logic [15:0] m0_dat_o_a, m1_dat_o_a, s_dat_o_a, m0_dat_o_b, m1_dat_o_b, s_dat_o_b;
    logic [19:0] s_adr_o_a, s_adr_o_b;
    logic        m0_ack_o_a, m1_ack_o_a, s_we_o_a, s_byte_o_a, s_stb_o_a, tmo_o_a;
    logic        m0_ack_o_b, m1_ack_o_b, s_we_o_b, s_byte_o_b, s_stb_o_b, tmo_o_b;
    logic [1:0]  gnt_o_a, gnt_o_b;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(.TIMEOUT(8), .M0_PRIORITY(1)) dut_a (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o_a),
        .m0_we_i(m0_we_i), .m0_byte_i(m0_byte_i), .m0_stb_i(m0_stb_i), .m0_ack_o(m0_ack_o_a),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o_a),
        .m1_we_i(m1_we_i), .m1_byte_i(m1_byte_i), .m1_stb_i(m1_stb_i), .m1_ack_o(m1_ack_o_a),
        .s_adr_o(s_adr_o_a), .s_dat_o(s_dat_o_a), .s_dat_i(s_dat_i), .s_we_o(s_we_o_a),
        .s_byte_o(s_byte_o_a), .s_stb_o(s_stb_o_a), .s_ack_i(s_ack_i),
        .tmo_o(tmo_o_a), .gnt_o(gnt_o_a)
    );

    mem_arbiter #(.TIMEOUT(5), .M0_PRIORITY(0)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o_b),
        .m0_we_i(m0_we_i), .m0_byte_i(m0_byte_i), .m0_stb_i(m0_stb_i), .m0_ack_o(m0_ack_o_b),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o_b),
        .m1_we_i(m1_we_i), .m1_byte_i(m1_byte_i), .m1_stb_i(m1_stb_i), .m1_ack_o(m1_ack_o_b),
        .s_adr_o(s_adr_o_b), .s_dat_o(s_dat_o_b), .s_dat_i(s_dat_i), .s_we_o(s_we_o_b),
        .s_byte_o(s_byte_o_b), .s_stb_o(s_stb_o_b), .s_ack_i(s_ack_i),
        .tmo_o(tmo_o_b), .gnt_o(gnt_o_b)
    );

    // bus layout: adr[38:19] dat[18:3] we[2] byte[1] stb[0]
    // mst layout: m0_dat[36:21] m0_ack[20] m1_dat[19:4] m1_ack[3] tmo[2] gnt[1:0]
    logic [38:0] obs_bus_a, obs_bus_b;
    logic [36:0] obs_mst_a, obs_mst_b;
    assign obs_bus_a = {s_adr_o_a, s_dat_o_a, s_we_o_a, s_byte_o_a, s_stb_o_a};
    assign obs_bus_b = {s_adr_o_b, s_dat_o_b, s_we_o_b, s_byte_o_b, s_stb_o_b};
    assign obs_mst_a = {m0_dat_o_a, m0_ack_o_a, m1_dat_o_a, m1_ack_o_a, tmo_o_a, gnt_o_a};
    assign obs_mst_b = {m0_dat_o_b, m0_ack_o_b, m1_dat_o_b, m1_ack_o_b, tmo_o_b, gnt_o_b};

    int total = 0;
    int bad   = 0;

    // Reference model state per instance: owner 0 = nobody, 1 = m0, 2 = m1.
    int owner  [2];
    int waited [2];   // grant cycles already spent without an ack
    int last_m [2];   // index of the master served last
    int prio   [2] = '{1, 0};
    int tlimit [2] = '{8, 5};

    logic [38:0] seen_bus [2];
    logic [36:0] seen_mst [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            owner[k]  = 0;
            waited[k] = 0;
            last_m[k] = 1;
        end
    endtask

    // Expected outputs of instance k for the current inputs and model state.
    task automatic model_out(input int k, output logic [38:0] eb, output logic [36:0] em);
        int g;
        logic req, to, ack, stb;
        logic [15:0] rd;
        g   = rst_i ? owner[k] : 0;
        req = (g == 1) ? m0_stb_i : ((g == 2) ? m1_stb_i : 1'b0);
        to  = (g != 0) && req && !s_ack_i && (waited[k] == tlimit[k] - 1);
        ack = (g != 0) && (s_ack_i || to);
        stb = req && !to;
        rd  = to ? 16'hFFFF : s_dat_i;
        if (g == 2) eb = {m1_adr_i, m1_dat_i, m1_we_i & stb, m1_byte_i, stb};
        else        eb = {m0_adr_i, m0_dat_i, m0_we_i & stb, m0_byte_i, stb};
        em = {(g == 1) ? rd : 16'h0000, (g == 1) && ack,
              (g == 2) ? rd : 16'h0000, (g == 2) && ack, to,
              (g == 1) ? 2'b01 : ((g == 2) ? 2'b10 : 2'b00)};
    endtask

    // Advance the model of instance k across one clock edge.
    task automatic model_adv(input int k);
        int g;
        logic req, to;
        g = owner[k];
        if (!rst_i) begin
            owner[k] = 0; waited[k] = 0; last_m[k] = 1;
        end else if (g == 0) begin
            if (m0_stb_i && m1_stb_i) owner[k] = (prio[k] == 1 || last_m[k] == 1) ? 1 : 2;
            else if (m0_stb_i)        owner[k] = 1;
            else if (m1_stb_i)        owner[k] = 2;
            waited[k] = 0;
        end else begin
            req = (g == 1) ? m0_stb_i : m1_stb_i;
            to  = req && !s_ack_i && (waited[k] == tlimit[k] - 1);
            if (s_ack_i || to) begin
                owner[k] = 0; waited[k] = 0; last_m[k] = g - 1;
            end else if (!req) begin
                owner[k] = 0; waited[k] = 0;
            end else begin
                waited[k] = waited[k] + 1;
            end
        end
    endtask

    // One clock: check both instances mid-cycle, then advance the model.
    task automatic step();
        logic [38:0] eb;
        logic [36:0] em;
        @(negedge clk_i);
        seen_bus[0] = obs_bus_a; seen_mst[0] = obs_mst_a;
        seen_bus[1] = obs_bus_b; seen_mst[1] = obs_mst_b;
        for (int k = 0; k < 2; k++) begin
            model_out(k, eb, em);
            chk(k == 0 ? "a_bus" : "b_bus", 64'(seen_bus[k]), 64'(eb));
            chk(k == 0 ? "a_mst" : "b_mst", 64'(seen_mst[k]), 64'(em));
        end
        @(posedge clk_i);
        for (int k = 0; k < 2; k++) model_adv(k);
        #1;
    endtask

    task automatic quiet();
        m0_stb_i = 1'b0; m1_stb_i = 1'b0; m0_we_i = 1'b0; m1_we_i = 1'b0;
        s_ack_i  = 1'b0; s_dat_i  = 16'h0000;
    endtask

    task automatic do_reset();
        quiet();
        rst_i = 1'b0;
        model_reset();
        step();
        step();
        rst_i = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        do_reset();
        chk("rst_gnt_a", 64'(seen_mst[0][1:0]), 64'(2'b00));
        chk("rst_stb_b", 64'(seen_bus[1][0]), 64'(1'b0));

        // Test 1: m0 read, slave acks in the 4th cycle.
        m0_adr_i = 20'hF0000; m0_we_i = 1'b0; m0_stb_i = 1'b1;
        step();                                                   // cycle 0
        step();                                                   // cycle 1
        chk("t1_gnt", 64'(seen_mst[0][1:0]), 64'(2'b01));
        chk("t1_sstb", 64'(seen_bus[0][0]), 64'(1'b1));
        chk("t1_adr", 64'(seen_bus[0][38:19]), 64'(20'hF0000));
        step(); step();                                           // cycles 2,3
        chk("t1_noack", 64'(seen_mst[0][20]), 64'(1'b0));
        s_ack_i = 1'b1; s_dat_i = 16'h1234;
        step();                                                   // cycle 4
        chk("t1_ack", 64'(seen_mst[0][20]), 64'(1'b1));
        chk("t1_dat", 64'(seen_mst[0][36:21]), 64'(16'h1234));
        quiet();
        step();
        chk("t1_idle", 64'(seen_mst[0][1:0]), 64'(2'b00));

        // Tests 2 and 3: both masters request forever, one-cycle slave.
        do_reset();
        m0_adr_i = 20'h11111; m1_adr_i = 20'h22222;
        m0_stb_i = 1'b1; m1_stb_i = 1'b1; s_ack_i = 1'b1; s_dat_i = 16'h0F0F;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t2_rr_gnt", 64'(seen_mst[1][1:0]),
                64'((i % 2 == 0) ? 2'b00 : (((i / 2) % 2 == 0) ? 2'b01 : 2'b10)));
            chk("t3_pri_gnt", 64'(seen_mst[0][1:0]), 64'((i % 2 == 0) ? 2'b00 : 2'b01));
            chk("t3_m1ack", 64'(seen_mst[0][3]), 64'(1'b0));
            chk("t3_adr", 64'(seen_bus[0][38:19]), 64'(20'h11111));
        end

        // Test 4: m1 write, slave never acks, m0 waits behind it.
        do_reset();
        m1_adr_i = 20'h00010; m1_dat_i = 16'hABCD; m1_we_i = 1'b1; m1_stb_i = 1'b1;
        step();                                                   // cycle 0
        m0_adr_i = 20'h00400; m0_stb_i = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            chk("t4_gnt", 64'(seen_mst[0][1:0]), 64'(2'b10));
            chk("t4_m0ack", 64'(seen_mst[0][20]), 64'(1'b0));
            chk("t4_tmo", 64'(seen_mst[0][2]), 64'(c == 8));
            chk("t4_m1ack", 64'(seen_mst[0][3]), 64'(c == 8));
            chk("t4_sstb", 64'(seen_bus[0][0]), 64'(c != 8));
        end
        chk("t4_m1dat", 64'(seen_mst[0][19:4]), 64'(16'hFFFF));
        m1_stb_i = 1'b0; m1_we_i = 1'b0;
        step();                                                   // cycle 9
        chk("t4_idle", 64'(seen_mst[0][1:0]), 64'(2'b00));
        s_ack_i = 1'b1; s_dat_i = 16'h5555;
        step();                                                   // cycle 10
        chk("t4_m0gnt", 64'(seen_mst[0][1:0]), 64'(2'b01));
        chk("t4_m0ack2", 64'(seen_mst[0][20]), 64'(1'b1));
        quiet();
        step();

        // Test 5: m0 aborts after two grant cycles; watchdog restarts at 0.
        do_reset();
        m0_adr_i = 20'h00ABC; m0_stb_i = 1'b1;
        step(); step(); step();                                   // cycles 0..2
        m0_stb_i = 1'b0;
        step();                                                   // cycle 3
        chk("t5_noack", 64'({seen_mst[0][20], seen_mst[0][3]}), 64'(2'b00));
        m0_stb_i = 1'b1;
        step();                                                   // cycle 4
        chk("t5_idle", 64'(seen_mst[0][1:0]), 64'(2'b00));
        for (int c = 5; c <= 12; c++) begin
            step();
            chk("t5_tmo", 64'(seen_mst[0][2]), 64'(c == 12));
        end
        quiet();
        step();

        // Test 6: asynchronous reset while the slave acks.
        do_reset();
        m0_stb_i = 1'b1;
        step(); step();                                           // granted
        s_ack_i = 1'b1; s_dat_i = 16'h7777;
        #2;
        rst_i = 1'b0;
        model_reset();
        #1;
        chk("t6_sstb", 64'({s_stb_o_a, s_stb_o_b}), 64'(2'b00));
        chk("t6_ack", 64'({m0_ack_o_a, m0_ack_o_b}), 64'(2'b00));
        chk("t6_gnt", 64'({gnt_o_a, gnt_o_b}), 64'(4'b0000));
        step();
        quiet();
        m0_stb_i = 1'b1; m1_stb_i = 1'b1;
        rst_i = 1'b1;
        step();
        step();
        chk("t6_tie_a", 64'(seen_mst[0][1:0]), 64'(2'b01));
        chk("t6_tie_b", 64'(seen_mst[1][1:0]), 64'(2'b01));
        quiet();
        step();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) m0_stb_i = ~m0_stb_i;
            if ($urandom_range(0, 5) == 0) m1_stb_i = ~m1_stb_i;
            m0_adr_i  = 20'($urandom); m1_adr_i  = 20'($urandom);
            m0_dat_i  = 16'($urandom); m1_dat_i  = 16'($urandom);
            m0_we_i   = 1'($urandom);  m1_we_i   = 1'($urandom);
            m0_byte_i = 1'($urandom);  m1_byte_i = 1'($urandom);
            s_dat_i   = 16'($urandom);
            s_ack_i   = ($urandom_range(0, 4) == 0);
            if (i == 300) begin
                do_reset();
            end else begin
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
